// File: rtl/snoop_bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// snoop_bus_ctrl_if
//   Bundles every signal between the snooping-bus controller and its
//   neighbours: the two L1 cache controllers (requests, write-backs, snoop
//   responses) and the single word-wide memory port.
//
//   Per-cache vectors are packed {c1, c0}.
//
//   modport master : the bus controller side (drives snoop, resp, wb_ack and
//                    the memory request; observes requests, snoop replies and
//                    memory replies)
//   modport slave  : the environment side (caches + memory), mirror image
// ----------------------------------------------------------------------------
interface snoop_bus_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   // cache requests
   logic [1:0]          req_valid;
   logic [3:0]          req_type;
   logic [2*ADDR_W-1:0] req_addr;

   // dirty write-backs
   logic [1:0]          wb_valid;
   logic [2*ADDR_W-1:0] wb_addr;
   logic [2*DATA_W-1:0] wb_data;
   logic [1:0]          wb_ack;

   // snoop broadcast and reply
   logic                snoop_valid;
   logic                snoop_src;
   logic [1:0]          snoop_type;
   logic [ADDR_W-1:0]   snoop_addr;
   logic [1:0]          snp_hit;
   logic [2*DATA_W-1:0] snp_data;

   // completion to the requester
   logic [1:0]          resp_valid;
   logic [DATA_W-1:0]   resp_data;
   logic                resp_err;

   // memory port
   logic                mem_valid;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_ready;
   logic [DATA_W-1:0]   mem_rdata;

   logic                bus_busy;

   modport master (
      input  req_valid, req_type, req_addr,
      input  wb_valid, wb_addr, wb_data,
      output wb_ack,
      output snoop_valid, snoop_src, snoop_type, snoop_addr,
      input  snp_hit, snp_data,
      output resp_valid, resp_data, resp_err,
      output mem_valid, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata,
      output bus_busy
   );

   modport slave (
      output req_valid, req_type, req_addr,
      output wb_valid, wb_addr, wb_data,
      input  wb_ack,
      input  snoop_valid, snoop_src, snoop_type, snoop_addr,
      output snp_hit, snp_data,
      input  resp_valid, resp_data, resp_err,
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata,
      input  bus_busy
   );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// ----------------------------------------------------------------------------
// snoop_bus_ctrl
//   Shared snooping-bus controller behind two L1 cache controllers. Arbitrates
//   miss/upgrade requests and dirty write-backs, broadcasts the granted request
//   as a snoop to the other cache, and returns the fill either cache-to-cache
//   (dirty snoop hit, also flushed to memory) or from memory. One transaction
//   in flight at a time.
//
// Ports
//   clk     : rising-edge clock
//   resetn  : synchronous active-low reset
//   bus     : snoop_bus_ctrl_if.master
//             req_valid/type/addr   per-cache requests (held until resp_valid)
//             wb_valid/addr/data    per-cache write-backs (held until wb_ack)
//             wb_ack                1-cycle write-back commit pulse
//             snoop_valid/src/type/addr  1-cycle snoop broadcast
//             snp_hit/snp_data      dirty-hit reply, 1 cycle after snoop_valid
//             resp_valid/data/err   1-cycle completion pulse to requester
//             mem_valid/we/addr/wdata, mem_ready/rdata   memory port
//             bus_busy              high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module snoop_bus_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 255
) (
   input logic              clk,
   input logic              resetn,
   snoop_bus_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      WB,
      SNOOP,
      SNP_WAIT,
      FLUSH,
      MEM_RD
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
   localparam logic [1:0] T_UPGR   = 2'b11;

   // per-cache views of the packed {c1, c0} buses
   logic [1:0]        rtype [2];
   logic [ADDR_W-1:0] raddr [2];
   logic [ADDR_W-1:0] waddr [2];
   logic [DATA_W-1:0] wdata [2];
   logic [DATA_W-1:0] sdata [2];

   assign rtype[0] = bus.req_type[1:0];
   assign rtype[1] = bus.req_type[3:2];
   assign raddr[0] = bus.req_addr[ADDR_W-1:0];
   assign raddr[1] = bus.req_addr[2*ADDR_W-1:ADDR_W];
   assign waddr[0] = bus.wb_addr[ADDR_W-1:0];
   assign waddr[1] = bus.wb_addr[2*ADDR_W-1:ADDR_W];
   assign wdata[0] = bus.wb_data[DATA_W-1:0];
   assign wdata[1] = bus.wb_data[2*DATA_W-1:DATA_W];
   assign sdata[0] = bus.snp_data[DATA_W-1:0];
   assign sdata[1] = bus.snp_data[2*DATA_W-1:DATA_W];

   // control state
   state_t            state_q, state_d;
   logic              rr_last_q, rr_last_d;
   logic              src_q, src_d;
   logic [7:0]        tmo_cnt_q, tmo_cnt_d;
   logic [1:0]        resp_valid_q, resp_valid_d;
   logic [1:0]        wb_ack_q, wb_ack_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;

   // transaction payload (no reset needed: only read in states that load it)
   logic [1:0]        type_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              lat_wb, lat_req, lat_snp;

   // combinational outputs
   logic              snoop_valid, snoop_src;
   logic [1:0]        snoop_type;
   logic [ADDR_W-1:0] snoop_addr;
   logic              mem_valid, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   logic [1:0]        req_ok, wb_ok;
   logic              grant;
   logic              tmo_hit;

   always_comb begin
      state_d      = state_q;
      rr_last_d    = rr_last_q;
      src_d        = src_q;
      tmo_cnt_d    = tmo_cnt_q;
      resp_valid_d = '0;
      wb_ack_d     = '0;
      resp_err_d   = 1'b0;
      resp_data_d  = '0;
      lat_wb       = 1'b0;
      lat_req      = 1'b0;
      lat_snp      = 1'b0;
      snoop_valid  = 1'b0;
      snoop_src    = 1'b0;
      snoop_type   = '0;
      snoop_addr   = '0;
      mem_valid    = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      grant        = 1'b0;

      // A requester only drops req_valid/wb_valid after seeing its pulse, so
      // the bit that is pulsing this cycle must not be re-granted in IDLE.
      req_ok  = bus.req_valid & ~resp_valid_q & {(rtype[1] != 2'b00), (rtype[0] != 2'b00)};
      wb_ok   = bus.wb_valid & ~wb_ack_q;
      tmo_hit = (tmo_cnt_q == TMO_LAST);

      case (state_q)
         IDLE: begin
            if (wb_ok != 2'b00) begin
               src_d     = ~wb_ok[0];
               lat_wb    = 1'b1;
               tmo_cnt_d = '0;
               state_d   = WB;
            end else if (req_ok != 2'b00) begin
               grant     = (req_ok == 2'b11) ? ~rr_last_q : req_ok[1];
               src_d     = grant;
               rr_last_d = grant;
               lat_req   = 1'b1;
               state_d   = SNOOP;
            end
         end

         WB: begin
            mem_valid = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = data_q;
            if (bus.mem_ready) begin
               wb_ack_d[src_q] = 1'b1;
               state_d         = IDLE;
            end else if (tmo_hit) begin
               wb_ack_d[src_q] = 1'b1;
               resp_err_d      = 1'b1;
               state_d         = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         SNOOP: begin
            snoop_valid = 1'b1;
            snoop_src   = src_q;
            snoop_type  = type_q;
            snoop_addr  = addr_q;
            state_d     = SNP_WAIT;
         end

         SNP_WAIT: begin
            if (type_q == T_UPGR) begin
               // upgrade needs no data whether or not the other cache hit
               resp_valid_d[src_q] = 1'b1;
               state_d             = IDLE;
            end else if (bus.snp_hit[~src_q]) begin
               resp_valid_d[src_q] = 1'b1;
               resp_data_d         = sdata[~src_q];
               lat_snp             = 1'b1;
               tmo_cnt_d           = '0;
               state_d             = FLUSH;
            end else begin
               tmo_cnt_d = '0;
               state_d   = MEM_RD;
            end
         end

         FLUSH: begin
            // keeps memory coherent with the dirty line already handed over;
            // the requester was answered on entry, so a timeout is silent
            mem_valid = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = data_q;
            if (bus.mem_ready || tmo_hit) begin
               state_d = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         MEM_RD: begin
            mem_valid = 1'b1;
            mem_addr  = addr_q;
            if (bus.mem_ready) begin
               resp_valid_d[src_q] = 1'b1;
               resp_data_d         = bus.mem_rdata;
               state_d             = IDLE;
            end else if (tmo_hit) begin
               resp_valid_d[src_q] = 1'b1;
               resp_err_d          = 1'b1;
               state_d             = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         rr_last_q    <= 1'b1;
         src_q        <= 1'b0;
         tmo_cnt_q    <= '0;
         resp_valid_q <= '0;
         wb_ack_q     <= '0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_last_q    <= rr_last_d;
         src_q        <= src_d;
         tmo_cnt_q    <= tmo_cnt_d;
         resp_valid_q <= resp_valid_d;
         wb_ack_q     <= wb_ack_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lat_wb) begin
         addr_q <= waddr[src_d];
         data_q <= wdata[src_d];
      end
      if (lat_req) begin
         addr_q <= raddr[src_d];
         type_q <= rtype[src_d];
      end
      if (lat_snp) begin
         data_q <= sdata[~src_q];
      end
   end

   assign bus.wb_ack      = wb_ack_q;
   assign bus.snoop_valid = snoop_valid;
   assign bus.snoop_src   = snoop_src;
   assign bus.snoop_type  = snoop_type;
   assign bus.snoop_addr  = snoop_addr;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.mem_valid   = mem_valid;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;
   assign bus.bus_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_snoop_bus_ctrl
//   Bench for snoop_bus_ctrl. An environment process plays both caches and
//   the memory: it raises requests/write-backs on demand, answers snoops one
//   cycle after snoop_valid and memory requests with zero wait states (or
//   never, to force a timeout). Expected snoops, memory transfers and
//   completions are queued when stimulus is issued and checked in order as
//   the DUT produces them.
// ----------------------------------------------------------------------------
module tb_snoop_bus_ctrl;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   snoop_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   snoop_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(255)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.master)
   );

   typedef struct packed {
      bit          is_wb;
      bit          c;
      logic [31:0] data;
      bit          err;
   } rsp_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } mw_t;

   typedef struct packed {
      bit            src;
      logic [1:0]    typ;
      logic [AW-1:0] addr;
   } snp_t;

   typedef struct {
      bit            c;
      logic [1:0]    typ;
      logic [AW-1:0] addr;
      bit            hit;
      logic [31:0]   sdata;
      logic [31:0]   mdata;
      logic [31:0]   exp_data;
      int            exp_lat;
      int            exp_mem;   // 0 none, 1 read, 2 write
   } vec_t;

   rsp_t          rsp_q[$];
   mw_t           wr_q[$];
   logic [AW-1:0] rd_q[$];
   snp_t          snp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // environment configuration (written by the test thread only)
   bit          cfg_hit;
   logic [31:0] cfg_sdata;
   logic [31:0] cfg_mdata;
   bit          mem_hang;
   int          req_issue[2];
   int          wb_issue[2];

   // environment state (written by the environment only)
   int cyc;
   int mv_cycles;
   int req_taken[2];
   int wb_taken[2];
   int raise_cyc[2];
   int last_lat[2];
   bit snp_pend;
   bit snp_pend_src;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic bad(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event occurred, required none", name);
   endtask

   task automatic take_rsp(input bit is_wb, input bit c);
      rsp_t r;
      if (rsp_q.size() == 0) begin
         bad(is_wb ? "unexpected_wb_ack" : "unexpected_resp");
         return;
      end
      r = rsp_q.pop_front();
      chk(is_wb ? "wb_ack_id" : "resp_id", {61'd0, is_wb, c, bus.resp_err},
          {61'd0, r.is_wb, r.c, r.err});
      if (!is_wb && !r.err) chk("resp_data", 64'(bus.resp_data), 64'(r.data));
   endtask

   // ---------------- environment: caches + memory ----------------
   initial begin : env
      snp_t s;
      mw_t  w;
      logic [AW-1:0] ra;
      bus.req_valid = '0;
      bus.wb_valid  = '0;
      bus.snp_hit   = '0;
      bus.snp_data  = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      cyc = 0; mv_cycles = 0; snp_pend = 0; snp_pend_src = 0;
      req_taken = '{0, 0}; wb_taken = '{0, 0};
      raise_cyc = '{0, 0}; last_lat = '{0, 0};
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         // snoop reply one cycle after snoop_valid, from the non-requester
         bus.snp_hit  = '0;
         bus.snp_data = '0;
         if (snp_pend && cfg_hit) begin
            if (snp_pend_src) begin
               bus.snp_hit[0]        = 1'b1;
               bus.snp_data[31:0]    = cfg_sdata;
               bus.snp_data[63:32]   = ~cfg_sdata;
            end else begin
               bus.snp_hit[1]        = 1'b1;
               bus.snp_data[63:32]   = cfg_sdata;
               bus.snp_data[31:0]    = ~cfg_sdata;
            end
         end
         snp_pend     = bus.snoop_valid;
         snp_pend_src = bus.snoop_src;
         // zero-wait memory
         bus.mem_ready = bus.mem_valid && !mem_hang;
         bus.mem_rdata = (bus.mem_ready && !bus.mem_we) ? cfg_mdata : '0;
         if (!resetn) begin
            bus.req_valid = '0;
            bus.wb_valid  = '0;
            snp_pend      = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (req_issue[i] != req_taken[i]) begin
               req_taken[i]++;
               bus.req_valid[i] = 1'b1;
               raise_cyc[i]     = cyc;
            end
            if (wb_issue[i] != wb_taken[i]) begin
               wb_taken[i]++;
               bus.wb_valid[i] = 1'b1;
            end
         end

         @(negedge clk);
         if (bus.mem_valid) mv_cycles++;
         if (bus.snoop_valid) begin
            if (snp_q.size() == 0) bad("unexpected_snoop");
            else begin
               s = snp_q.pop_front();
               chk("snoop", 64'({bus.snoop_src, bus.snoop_type, bus.snoop_addr}),
                   64'({s.src, s.typ, s.addr}));
            end
         end
         if (bus.mem_valid && bus.mem_ready) begin
            if (bus.mem_we) begin
               if (wr_q.size() == 0) bad("unexpected_mem_write");
               else begin
                  w = wr_q.pop_front();
                  chk("mem_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'({w.addr, w.data}));
               end
            end else begin
               if (rd_q.size() == 0) bad("unexpected_mem_read");
               else begin
                  ra = rd_q.pop_front();
                  chk("mem_read_addr", 64'(bus.mem_addr), 64'(ra));
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (bus.wb_ack[i]) begin
               take_rsp(1'b1, 1'(i));
               bus.wb_valid[i] = 1'b0;
            end
            if (bus.resp_valid[i]) begin
               take_rsp(1'b0, 1'(i));
               last_lat[i]      = cyc - raise_cyc[i];
               bus.req_valid[i] = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test-thread helpers ----------------
   function automatic bit tb_busy();
      return (rsp_q.size() != 0) || (wr_q.size() != 0) || (rd_q.size() != 0) ||
             (snp_q.size() != 0) || (bus.bus_busy !== 1'b0) ||
             (bus.req_valid != 2'b00) || (bus.wb_valid != 2'b00) ||
             (req_issue[0] != req_taken[0]) || (req_issue[1] != req_taken[1]) ||
             (wb_issue[0] != wb_taken[0]) || (wb_issue[1] != wb_taken[1]);
   endfunction

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (tb_busy() && n < budget);
      if (n >= budget) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout_%s: still busy after %0d cycles, required idle", tag, n);
      end
   endtask

   task automatic issue_req(input bit c, input logic [1:0] typ, input logic [AW-1:0] addr);
      if (c) begin
         bus.req_type[3:2]       = typ;
         bus.req_addr[2*AW-1:AW] = addr;
      end else begin
         bus.req_type[1:0]       = typ;
         bus.req_addr[AW-1:0]    = addr;
      end
      req_issue[c]++;
   endtask

   // ---------------- test sequence ----------------
   vec_t vt[7];
   int   mv0;
   int   left[2];
   int   n;

   initial begin : main
      vt[0] = '{1'b0, 2'b01, 10'h3FC, 1'b0, 32'h0,         32'h0000_0002, 32'h0000_0002, 4, 1};
      vt[1] = '{1'b1, 2'b10, 10'h010, 1'b1, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 3, 2};
      vt[2] = '{1'b0, 2'b11, 10'h020, 1'b0, 32'h0,         32'h0,         32'h0,         3, 0};
      vt[3] = '{1'b1, 2'b11, 10'h024, 1'b1, 32'h1234_5678, 32'h0,         32'h0,         3, 0};
      vt[4] = '{1'b1, 2'b01, 10'h1FF, 1'b0, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 4, 1};
      vt[5] = '{1'b0, 2'b10, 10'h000, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 3, 2};
      vt[6] = '{1'b0, 2'b10, 10'h2A8, 1'b0, 32'h0,         32'h8000_0001, 32'h8000_0001, 4, 1};

      resetn       = 1'b0;
      bus.req_type = '0;
      bus.req_addr = '0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      cfg_hit = 0; cfg_sdata = '0; cfg_mdata = '0; mem_hang = 0;
      req_issue = '{0, 0}; wb_issue = '{0, 0};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_bus_busy",    64'(bus.bus_busy),    64'd0);
      chk("rst_mem_valid",   64'(bus.mem_valid),   64'd0);
      chk("rst_snoop_valid", 64'(bus.snoop_valid), 64'd0);
      chk("rst_resp_valid",  64'(bus.resp_valid),  64'd0);
      chk("rst_wb_ack",      64'(bus.wb_ack),      64'd0);
      chk("rst_resp_err",    64'(bus.resp_err),    64'd0);
      chk("rst_resp_data",   64'(bus.resp_data),   64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // single-requester transactions from the table
      for (int k = 0; k < 7; k++) begin
         cfg_hit   = vt[k].hit;
         cfg_sdata = vt[k].sdata;
         cfg_mdata = vt[k].mdata;
         snp_q.push_back('{vt[k].c, vt[k].typ, vt[k].addr});
         rsp_q.push_back('{1'b0, vt[k].c, vt[k].exp_data, 1'b0});
         if (vt[k].exp_mem == 1) rd_q.push_back(vt[k].addr);
         if (vt[k].exp_mem == 2) wr_q.push_back('{vt[k].addr, vt[k].exp_data});
         mv0 = mv_cycles;
         issue_req(vt[k].c, vt[k].typ, vt[k].addr);
         wait_idle(60, "vec");
         chk("latency", 64'(last_lat[vt[k].c]), 64'(vt[k].exp_lat));
         if (vt[k].exp_mem == 0) chk("upgr_no_mem", 64'(mv_cycles - mv0), 64'd0);
      end

      // write-back and request in the same cycle: write-back wins
      cfg_hit   = 0;
      cfg_mdata = 32'h0BAD_F00D;
      bus.wb_addr[2*AW-1:AW] = 10'h155;
      bus.wb_data[63:32]     = 32'h5A5A_A5A5;
      wr_q.push_back('{10'h155, 32'h5A5A_A5A5});
      rsp_q.push_back('{1'b1, 1'b1, 32'h0, 1'b0});
      snp_q.push_back('{1'b0, 2'b01, 10'h0C4});
      rd_q.push_back(10'h0C4);
      rsp_q.push_back('{1'b0, 1'b0, 32'h0BAD_F00D, 1'b0});
      wb_issue[1]++;
      issue_req(1'b0, 2'b01, 10'h0C4);
      wait_idle(60, "wb_first");

      // memory never answers a read: timeout with resp_err
      mem_hang = 1;
      snp_q.push_back('{1'b0, 2'b01, 10'h3F0});
      rsp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b1});
      mv0 = mv_cycles;
      issue_req(1'b0, 2'b01, 10'h3F0);
      wait_idle(600, "mem_timeout");
      chk("tmo_mem_valid_cycles", 64'(mv_cycles - mv0), 64'd255);
      chk("tmo_bus_busy", 64'(bus.bus_busy), 64'd0);

      // reset in the middle of a memory read: aborted without a response
      snp_q.push_back('{1'b1, 2'b01, 10'h0AA});
      issue_req(1'b1, 2'b01, 10'h0AA);
      repeat (10) @(negedge clk);
      #1;
      chk("mid_busy_before_rst", 64'(bus.bus_busy), 64'd1);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("mid_rst_busy", 64'(bus.bus_busy), 64'd0);
      chk("mid_rst_mem_valid", 64'(bus.mem_valid), 64'd0);
      mem_hang = 0;
      resetn   = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("post_rst_idle", 64'(bus.bus_busy), 64'd0);

      // both caches contend for 10 upgrades: grants alternate starting with c0
      cfg_hit = 0;
      for (int k = 0; k < 10; k++) begin
         snp_q.push_back('{1'(k % 2), 2'b11, (k % 2) ? 10'h080 : 10'h040});
         rsp_q.push_back('{1'b0, 1'(k % 2), 32'h0, 1'b0});
      end
      issue_req(1'b0, 2'b11, 10'h040);
      issue_req(1'b1, 2'b11, 10'h080);
      left = '{4, 4};
      n = 0;
      while (((left[0] + left[1]) > 0 || tb_busy()) && n < 400) begin
         @(negedge clk);
         #1;
         n++;
         for (int i = 0; i < 2; i++) begin
            if (left[i] > 0 && bus.req_valid[i] == 1'b0 && req_issue[i] == req_taken[i]) begin
               issue_req(1'(i), 2'b11, (i == 1) ? 10'h080 : 10'h040);
               left[i]--;
            end
         end
      end
      if (n >= 400) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout_stream: %0d cycles, required completion", n);
      end

      // after a lone c0 grant, a simultaneous pair goes to c1 first
      snp_q.push_back('{1'b0, 2'b11, 10'h044});
      rsp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b0});
      issue_req(1'b0, 2'b11, 10'h044);
      wait_idle(40, "lone_c0");
      snp_q.push_back('{1'b1, 2'b11, 10'h088});
      rsp_q.push_back('{1'b0, 1'b1, 32'h0, 1'b0});
      snp_q.push_back('{1'b0, 2'b11, 10'h048});
      rsp_q.push_back('{1'b0, 1'b0, 32'h0, 1'b0});
      issue_req(1'b0, 2'b11, 10'h048);
      issue_req(1'b1, 2'b11, 10'h088);
      wait_idle(60, "rr_tie");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
